inv_subbytes_addkey: RTL and testbench

Byte-serial AES decryption stage that applies InvSubBytes and then AddRoundKey to a 128-bit state, one byte per clock through a single inverse S-box. It sits directly upstream of the combinational invMixColumns block: its `state_out` feeds invMixColumns `in`, using the same packed `[15:0][7:0]` byte layout. A `key_only` mode performs AddRoundKey alone, which covers the initial decryption round. Valid/ready handshakes on both sides let the round controller stall the stage.

---
 rtl/inv_subbytes_addkey.sv | 119 +++++++++++
 tb/tb_inv_subbytes_addkey.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_addkey.sv
`default_nettype none
// ============================================================================
// Module      : inv_subbytes_addkey
// Description : Byte-serial AES decryption stage. Applies InvSubBytes followed
//               by AddRoundKey to a 128-bit state, one byte per clock through
//               a single inverse S-box. With key_only set, the S-box is
//               bypassed and only AddRoundKey is applied.
// Ports       : clk, rst_n              clock, synchronous active-low reset
//               in_valid / in_ready     input handshake (ready only in IDLE)
//               state_in, round_key     packed [15:0][7:0], byte i = [i]
//               key_only                1: XOR only, 0: InvSbox then XOR
//               out_valid / out_ready   output handshake (valid in DONE)
//               state_out               result, feeds invMixColumns 'in'
//               busy                    high in RUN and DONE
// Revision    : 1.0 - initial release
// ============================================================================
module inv_subbytes_addkey (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0][7:0] state_in,
    input  logic [15:0][7:0] round_key,
    input  logic             key_only,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0][7:0] state_out,
    output logic             busy
);

    // FIPS-197 inverse S-box. Index 0 is the leftmost byte of the table.
    localparam logic [0:255][7:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [15:0][7:0] r_work;
    logic [15:0][7:0] r_key;
    logic            r_mode;
    logic [3:0]      r_idx;

    logic [7:0]      w_cur;
    logic [7:0]      w_sub;
    logic [7:0]      w_new;

    // Datapath for the byte currently selected by r_idx.
    assign w_cur = r_work[r_idx];
    assign w_sub = c_INV_SBOX[w_cur];
    assign w_new = (r_mode ? w_cur : w_sub) ^ r_key[r_idx];

    // Handshake flags depend on the state register only.
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state == c_RUN) || (r_state == c_DONE);
    assign state_out = r_work;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_work  <= '0;
            r_key   <= '0;
            r_mode  <= 1'b0;
            r_idx   <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_work  <= state_in;
                        r_key   <= round_key;
                        r_mode  <= key_only;
                        r_idx   <= 4'd0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_work[r_idx] <= w_new;
                    // Index stays at 15 on the last byte; it is reloaded on
                    // the next acceptance, so it never wraps within a block.
                    if (r_idx == 4'd15) begin
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_subbytes_addkey.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_subbytes_addkey
// Description : Self-checking bench for inv_subbytes_addkey. The reference
//               inverse S-box is derived from GF(2^8) inversion plus the
//               forward affine map, then inverted by table construction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_subbytes_addkey;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0][7:0] state_in;
    logic [15:0][7:0] round_key;
    logic             key_only;
    logic             out_valid;
    logic             out_ready;
    logic [15:0][7:0] state_out;
    logic             busy;

    inv_subbytes_addkey u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .key_only  (key_only),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk;
    int         n_pass;
    logic [7:0] inv_tab [256];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] fsbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        if (x != 8'h00) begin
            for (int z = 1; z < 256; z++) begin
                if (gmul(x, z[7:0]) == 8'h01) b = z[7:0];
            end
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic ko);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = s[i*8 +: 8];
            r[i*8 +: 8] = (ko ? b : inv_tab[b]) ^ k[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge while idle. Returns the captured result, the
    // latency in edges after acceptance and the number of busy cycles seen.
    task automatic run(input logic [127:0] s, input logic [127:0] k, input logic ko,
                       output logic [127:0] res, output int lat, output int bcnt);
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
        key_only  = ko;
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        state_in  = rnd128();
        round_key = rnd128();
        key_only  = ~ko;
        lat  = -1;
        bcnt = 0;
        res  = '0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (busy) bcnt++;
            if (out_valid) begin
                lat = n;
                res = state_out;
                break;
            end
        end
        if (lat < 0) $display("FAIL out_valid_timeout: got none expected within 40 cycles");
    endtask

    // One negedge after the handoff edge the stage must be idle again.
    task automatic post_handoff(input string nm, input logic [127:0] res);
        @(negedge clk);
        chk({nm, "_ov_low"}, out_valid, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_held"}, state_out, res);
    endtask

    typedef struct {
        string        name;
        logic [127:0] s;
        logic [127:0] k;
        logic         ko;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [127:0] res;
        logic [127:0] ra;
        logic [127:0] bs [3];
        logic [127:0] bk [3];
        logic         bko [3];
        logic [127:0] bres [3];
        int           acc [3];
        int           lat;
        int           bcnt;
        int           j;
        int           r;
        logic         seen;

        n_chk  = 0;
        n_pass = 0;
        for (int x = 0; x < 256; x++) inv_tab[fsbox(x[7:0])] = x[7:0];

        vecs[0] = '{"zero_block", '0, '0, 1'b0, {16{8'h52}}};
        vecs[1] = '{"ident_63", {16{8'h63}}, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                    128'h0f0e0d0c0b0a09080706050403020100};
        vecs[2] = '{"ident_7c", {16{8'h7c}}, '0, 1'b0, {16{8'h01}}};
        vecs[3] = '{"key_only", 128'h04e0482866cbf8068119d326e59a7a4c, {16{8'hff}}, 1'b1,
                    128'hfb1fb7d7993407f97ee62cd91a6585b3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        state_in  = '0;
        round_key = '0;
        key_only  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_state_out", state_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- directed vectors ----------------
        for (int v = 0; v < 4; v++) begin
            run(vecs[v].s, vecs[v].k, vecs[v].ko, res, lat, bcnt);
            chk({vecs[v].name, "_data"}, res, vecs[v].exp);
            chk({vecs[v].name, "_latency"}, lat, 16);
            chk({vecs[v].name, "_busy_cycles"}, bcnt, 17);
            post_handoff(vecs[v].name, res);
        end

        // ---------------- randomized blocks vs model ----------------
        for (int t = 0; t < 12; t++) begin
            logic [127:0] s;
            logic [127:0] k;
            logic         ko;
            s  = rnd128();
            k  = rnd128();
            ko = 1'($urandom_range(0, 1));
            run(s, k, ko, res, lat, bcnt);
            chk("rand_data", res, model(s, k, ko));
            chk("rand_latency", lat, 16);
            post_handoff("rand", res);
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        ra = rnd128();
        run(ra, {16{8'h5a}}, 1'b0, res, lat, bcnt);
        chk("bp_data", res, model(ra, {16{8'h5a}}, 1'b0));
        chk("bp_latency", lat, 16);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            state_in  = rnd128();
            round_key = rnd128();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_state_out", state_out, res);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        post_handoff("bp", res);
        repeat (3) @(negedge clk);
        chk("bp_new_block_not_taken", busy, 0);

        // ---------------- reset mid-run ----------------
        in_valid  = 1'b1;
        state_in  = rnd128();
        round_key = rnd128();
        key_only  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_state_out", state_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("mid_rst_no_output", seen, 0);
        run('0, '0, 1'b0, res, lat, bcnt);
        chk("post_rst_zero_data", res, {16{8'h52}});
        chk("post_rst_zero_latency", lat, 16);
        post_handoff("post_rst", res);

        // ---------------- back-to-back ----------------
        for (int i = 0; i < 3; i++) begin
            bs[i]  = rnd128();
            bk[i]  = rnd128();
            bko[i] = (i == 1);
            acc[i] = -1;
            bres[i] = '0;
        end
        out_ready = 1'b1;
        j = 0;
        r = 0;
        for (int c = 0; c < 100 && r < 3; c++) begin
            if (j < 3) begin
                in_valid  = 1'b1;
                state_in  = bs[j];
                round_key = bk[j];
                key_only  = bko[j];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                bres[r] = state_out;
                r++;
            end
            if (in_ready && in_valid) begin
                acc[j] = c;
                j++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_results_seen", r, 3);
        chk("b2b_gap_01", acc[1] - acc[0], 18);
        chk("b2b_gap_12", acc[2] - acc[1], 18);
        for (int i = 0; i < 3; i++) chk("b2b_data", bres[i], model(bs[i], bk[i], bko[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
